key_debounce_encoder: RTL and testbench
=======================================

KEY_DEBOUNCE_ENCODER -- requirements
Module: key_debounce_encoder

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 2000000, meaning consecutive cycles a raw level must hold before it is accepted (20 ms at 100 MHz); legal range 2..2^24-1.
REQ-002 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port key_raw  input  8  asynchronous, bouncing piano key switches; bit i = key i.
REQ-005 SHALL have port key_board_in  output  8  debounced one-hot key vector, fed directly to the mode FSM's key_board_in; all zeros when no key or more than one key is held.
REQ-006 SHALL have port key_code  output  3  binary index of the set bit of key_board_in; 0 when key_board_in is zero.
REQ-007 SHALL have port key_press  output  1  one-cycle pulse, asserted in the same cycle key_board_in first becomes non-zero.
REQ-008 SHALL have port key_release  output  1  one-cycle pulse, asserted in the same cycle key_board_in returns to zero from a valid key.

Function
REQ-009 SHALL pass each key_raw bit through a two-flop synchronizer (sync) before any other use.
REQ-010 SHALL keep, per bit, a debounced level (stable) and a counter wide enough for DEBOUNCE_CYCLES-1.
REQ-011 SHALL, per bit, clear the counter in every cycle where sync equals stable.
REQ-012 SHALL, per bit, increment the counter in every cycle where sync differs from stable and the counter is below DEBOUNCE_CYCLES-1.
REQ-013 SHALL, per bit, load stable from sync and clear the counter when sync differs and the counter equals DEBOUNCE_CYCLES-1, so stable changes on the DEBOUNCE_CYCLES-th consecutive disagreeing cycle.
REQ-014 SHALL ignore glitches shorter than DEBOUNCE_CYCLES cycles at sync; stable is unchanged.
REQ-015 SHALL implement an output FSM with states IDLE, PRESSED and MULTI, driven by the stable vector.
REQ-016 IDLE: stable zero -> stay; stable one-hot -> PRESSED, with key_board_in loaded from stable, key_code set and key_press pulsed; stable with 2 or more bits set -> MULTI, outputs stay zero, no pulse.
REQ-017 PRESSED: stable equal to the latched key -> stay; stable zero -> IDLE, key_board_in and key_code cleared, key_release pulsed.
REQ-018 PRESSED: any other stable value (extra key added, or key swapped within one cycle) -> MULTI, key_board_in and key_code cleared, key_release pulsed.
REQ-019 MULTI: outputs held zero; SHALL leave only when stable is all zeros, going to IDLE with no pulse, so a valid key requires full release first.
REQ-020 All outputs SHALL be registered; key_press and key_release SHALL never assert in the same cycle or for more than one cycle.
REQ-021 Latency from a clean raw edge (sampled at edge k) to key_board_in/key_press SHALL be exactly 2 + DEBOUNCE_CYCLES + 1 rising edges; release latency SHALL be identical.

Reset
REQ-022 While rst is high, the synchronizer flops, stable, counters, key_board_in, key_code, key_press and key_release SHALL all be 0 and the FSM SHALL be IDLE.
REQ-023 Reset asserted mid-debounce or mid-press SHALL discard all progress; after release, a key still held is detected again with full REQ-021 latency and a fresh key_press.

Verification (DEBOUNCE_CYCLES=4)
REQ-024 Reset, then key_raw=8'b0010_0000 held -> key_board_in=8'b0010_0000, key_code=5, and a single key_press exactly 7 cycles after the first sampling edge.
REQ-025 key_raw bit 3 toggles with high pulses 1-3 cycles long and 1-cycle gaps, then holds high -> no output until 4 consecutive synced-high cycles, then one key_press with key_board_in=8'b0000_1000.
REQ-026 Key 6 held and valid, then key 1 also pressed -> key_board_in=0 and one key_release pulse; releasing only key 6 -> outputs stay 0; releasing all, then pressing key 1 -> key_board_in=8'b0000_0010 with key_press.
REQ-027 Sequence keys 5,3,6,1,4,0,2,7, each held 10 debounce periods with full release between -> key_board_in shows each one-hot value in order, with exactly 8 key_press and 8 key_release pulses.
REQ-028 rst pulsed for 1 cycle while key 4 is held and valid -> all outputs 0 next cycle, no key_release; key_press for key 4 reappears 7 cycles after rst deasserts.

Source files
------------

// File: rtl/key_debounce_encoder.sv
// key_debounce_encoder: synchronize and debounce 8 piano keys, then encode a single held key
module key_debounce_encoder #(
   parameter int DEBOUNCE_CYCLES = 2000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] key_raw,
   output logic [7:0] key_board_in,
   output logic [2:0] key_code,
   output logic       key_press,
   output logic       key_release
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
   typedef enum logic [1:0] {IDLE, PRESSED, MULTI} state_t;
   state_t state;
   logic [7:0] sync1, sync2, stable;
   logic [CW-1:0] cnt [8];
   logic [2:0] enc;
   logic one_hot;
   // two-flop synchronizer for the asynchronous key inputs
   always_ff @(posedge clk) begin
      sync1 <= rst ? '0 : key_raw;
      sync2 <= rst ? '0 : sync1;
   end
   // per-key debounce: accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing cycles
   always_ff @(posedge clk) begin
      for (int i = 0; i < 8; i++) begin
         if (rst || sync2[i] == stable[i]) begin
            cnt[i] <= '0;
            if (rst) stable[i] <= 1'b0;
         end else if (cnt[i] == CMAX) begin
            stable[i] <= sync2[i];
            cnt[i]    <= '0;
         end else begin
            cnt[i] <= cnt[i] + 1'b1;
         end
      end
   end
   // binary index of the highest set bit; meaningful only when stable is one-hot
   always_comb begin
      enc = '0;
      for (int i = 0; i < 8; i++) if (stable[i]) enc = 3'(i);
      one_hot = (stable != 8'd0) && ((stable & (stable - 8'd1)) == 8'd0);
   end
   // output FSM: a valid key needs a one-hot vector from full release; chords lock out until all keys are up
   always_ff @(posedge clk) begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
      if (rst) begin
         state        <= IDLE;
         key_board_in <= '0;
         key_code     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (one_hot) begin
                  state        <= PRESSED;
                  key_board_in <= stable;
                  key_code     <= enc;
                  key_press    <= 1'b1;
               end else if (stable != 8'd0) begin
                  state <= MULTI;
               end
            end
            PRESSED: begin
               if (stable != key_board_in) begin
                  state        <= (stable == 8'd0) ? IDLE : MULTI;
                  key_board_in <= '0;
                  key_code     <= '0;
                  key_release  <= 1'b1;
               end
            end
            MULTI: begin
               if (stable == 8'd0) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_key_debounce_encoder.sv
// tb_key_debounce_encoder: directed checks of debounce latency, glitch rejection, chord lockout and reset
module tb_key_debounce_encoder;
   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] key_raw;
   logic [7:0] key_board_in;
   logic [2:0] key_code;
   logic       key_press, key_release;
   int checks = 0, failures = 0;
   int n_press = 0, n_release = 0, n_both = 0;
   key_debounce_encoder #(.DEBOUNCE_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .key_raw(key_raw), .key_board_in(key_board_in),
      .key_code(key_code), .key_press(key_press), .key_release(key_release)
   );
   always #5 clk = ~clk;
   // pulse tally sampled away from the active edge
   always @(negedge clk) begin
      if (key_press) n_press++;
      if (key_release) n_release++;
      if (key_press && key_release) n_both++;
   end
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   // hold key_raw and expect a press exactly on the 7th edge (2 sync + 4 debounce + 1 fsm)
   task automatic press_key(input string tag, input logic [7:0] raw, input logic [2:0] code);
      key_raw = raw;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk({tag, "_early_press"}, {31'd0, key_press}, 32'd0);
      end
      tick();
      chk({tag, "_press"}, {31'd0, key_press}, 32'd1);
      chk({tag, "_kbi"}, {24'd0, key_board_in}, {24'd0, raw});
      chk({tag, "_code"}, {29'd0, key_code}, {29'd0, code});
   endtask
   int p0, r0;
   logic [2:0] seq [8] = '{3'd5, 3'd3, 3'd6, 3'd1, 3'd4, 3'd0, 3'd2, 3'd7};
   initial begin
      rst = 1'b1;
      key_raw = 8'hFF;
      tick(3);
      chk("rst_kbi", {24'd0, key_board_in}, 32'd0);
      chk("rst_code", {29'd0, key_code}, 32'd0);
      chk("rst_press", {31'd0, key_press}, 32'd0);
      chk("rst_release", {31'd0, key_release}, 32'd0);
      rst = 1'b0;
      key_raw = 8'h00;
      tick(3);
      // single key 5 with exact press and release latency
      press_key("k5", 8'b0010_0000, 3'd5);
      tick();
      chk("k5_press_one_cycle", {31'd0, key_press}, 32'd0);
      chk("k5_hold", {24'd0, key_board_in}, 32'h20);
      key_raw = 8'h00;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("k5_early_release", {31'd0, key_release}, 32'd0);
      end
      tick();
      chk("k5_release", {31'd0, key_release}, 32'd1);
      chk("k5_rel_kbi", {24'd0, key_board_in}, 32'd0);
      chk("k5_rel_code", {29'd0, key_code}, 32'd0);
      tick(3);
      // bouncing key 3: high runs of 1,2,3 cycles with single-cycle gaps are rejected
      begin
         logic [8:0] bounce;
         bounce = 9'b1_0111_0110;
         for (int i = 8; i >= 0; i--) begin
            key_raw = {4'd0, bounce[i], 3'd0};
            tick();
            chk("bounce_kbi", {24'd0, key_board_in}, 32'd0);
            chk("bounce_press", {31'd0, key_press}, 32'd0);
         end
      end
      key_raw = 8'h00;
      tick();
      press_key("k3", 8'b0000_1000, 3'd3);
      key_raw = 8'h00;
      tick(10);
      chk("k3_released", {24'd0, key_board_in}, 32'd0);
      // chord lockout: key 6 valid, add key 1
      press_key("k6", 8'b0100_0000, 3'd6);
      key_raw = 8'b0100_0010;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("chord_early_release", {31'd0, key_release}, 32'd0);
      end
      tick();
      chk("chord_release", {31'd0, key_release}, 32'd1);
      chk("chord_kbi", {24'd0, key_board_in}, 32'd0);
      p0 = n_press;
      key_raw = 8'b0000_0010;
      tick(12);
      chk("lock_kbi", {24'd0, key_board_in}, 32'd0);
      chk("lock_no_press", n_press - p0, 32'd0);
      key_raw = 8'h00;
      tick(10);
      press_key("k1", 8'b0000_0010, 3'd1);
      key_raw = 8'h00;
      tick(10);
      chk("k1_released", {24'd0, key_board_in}, 32'd0);
      // scan sequence with full release between keys
      p0 = n_press;
      r0 = n_release;
      for (int k = 0; k < 8; k++) begin
         press_key("seq", 8'd1 << seq[k], seq[k]);
         tick(33);
         chk("seq_hold", {24'd0, key_board_in}, {24'd0, 8'd1 << seq[k]});
         key_raw = 8'h00;
         tick(40);
         chk("seq_rel_kbi", {24'd0, key_board_in}, 32'd0);
      end
      chk("seq_press_count", n_press - p0, 32'd8);
      chk("seq_release_count", n_release - r0, 32'd8);
      // reset while key 4 is valid
      press_key("k4", 8'b0001_0000, 3'd4);
      tick(2);
      r0 = n_release;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_mid_kbi", {24'd0, key_board_in}, 32'd0);
      chk("rst_mid_code", {29'd0, key_code}, 32'd0);
      chk("rst_mid_release", {31'd0, key_release}, 32'd0);
      press_key("k4_again", 8'b0001_0000, 3'd4);
      chk("rst_no_release", n_release - r0, 32'd0);
      key_raw = 8'h00;
      tick(10);
      chk("never_both", n_both, 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
